// File: rtl/fulladd_bist_pkg.sv
// Shared constants, state encoding and pipeline stage type for the full-adder BIST.
package fulladd_bist_pkg;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned MAX_LAT = 3;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // One entry of the expected-result delay line.
  typedef struct packed {
    logic       vld;
    logic [2:0] vec;
    logic       s;
    logic       cout;
  } exp_t;

endpackage

// File: rtl/fulladd_bist_if.sv
// Bus between the BIST controller (master) and the adder under test (slave).
interface fulladd_bist_if;
  logic dut_a;
  logic dut_b;
  logic dut_cin;
  logic dut_s;
  logic dut_cout;

  modport master (
    output dut_a,
    output dut_b,
    output dut_cin,
    input  dut_s,
    input  dut_cout
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_cin,
    output dut_s,
    output dut_cout
  );
endinterface

// File: rtl/fulladd_gate.sv
// Gate-level one-bit full adder; serves as the golden reference model.
module fulladd_gate (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  logic ab_x;

  assign ab_x   = a_i ^ b_i;
  assign s_o    = ab_x ^ cin_i;
  assign cout_o = (a_i & b_i) | (ab_x & cin_i);
endmodule

// File: rtl/fulladd_bist.sv
// Exhaustive BIST for a one-bit full adder: sweeps all 8 input vectors and compares
// the returned sum/carry against a golden adder delayed by the DUT latency.
module fulladd_bist
  import fulladd_bist_pkg::*;
#(
  parameter int unsigned LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  fulladd_bist_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [3:0]     err_cnt,
  output logic [2:0]     fail_vec,
  output logic           fail_valid
);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] stim_q, stim_d;
  logic       stim_vld_q, stim_vld_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fvec_q, fvec_d;
  logic       fvalid_q, fvalid_d;

  logic gold_s, gold_cout;
  logic mismatch;
  exp_t cur, cmp;

  fulladd_gate u_gold (
    .a_i   (stim_q[2]),
    .b_i   (stim_q[1]),
    .cin_i (stim_q[0]),
    .s_o   (gold_s),
    .cout_o(gold_cout)
  );

  assign cur = {stim_vld_q, stim_q, gold_s, gold_cout};

  if (LAT > MAX_LAT) begin : g_bad_lat
    $error("fulladd_bist: LAT out of range");
  end

  // Expected results ride alongside the DUT's own latency.
  if (LAT == 0) begin : g_no_pipe
    assign cmp = cur;
  end else begin : g_pipe
    exp_t pipe_q [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= cur;
        for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign cmp = pipe_q[LAT-1];
  end

  assign mismatch = (state_q == StRun) && cmp.vld &&
                    ((bus.dut_s != cmp.s) || (bus.dut_cout != cmp.cout));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stim_d     = 3'b000;
    stim_vld_d = 1'b0;
    err_d      = err_q;
    fvec_d     = fvec_q;
    fvalid_d   = fvalid_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          cnt_d    = 4'd0;
          err_d    = 4'd0;
          fvec_d   = 3'b000;
          fvalid_d = 1'b0;
        end
      end
      StRun: begin
        if (cnt_q < 4'(NUM_VEC)) begin
          stim_d     = cnt_q[2:0];
          stim_vld_d = 1'b1;
          cnt_d      = cnt_q + 4'd1;
        end
        if (mismatch) begin
          if (err_q < 4'(NUM_VEC)) err_d = err_q + 4'd1;
          if (!fvalid_q) begin
            fvec_d   = cmp.vec;
            fvalid_d = 1'b1;
          end
        end
        // Last vector's compare ends the sweep; pipeline is empty by then.
        if (cmp.vld && (cmp.vec == 3'(NUM_VEC - 1))) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      stim_q     <= 3'b000;
      stim_vld_q <= 1'b0;
      err_q      <= 4'd0;
      fvec_q     <= 3'b000;
      fvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stim_q     <= stim_d;
      stim_vld_q <= stim_vld_d;
      err_q      <= err_d;
      fvec_q     <= fvec_d;
      fvalid_q   <= fvalid_d;
    end
  end

  assign bus.dut_a   = stim_q[2];
  assign bus.dut_b   = stim_q[1];
  assign bus.dut_cin = stim_q[0];

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign pass       = done && (err_q == 4'd0);
  assign err_cnt    = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;

endmodule
